control_sequencer: RTL and testbench

//  Multi-cycle control unit driving the 8-bit register/ALU datapath: fetches 16-bit instructions, decodes them

---
 rtl/control_sequencer_pkg.sv | 46 ++++
 rtl/control_sequencer_instr_decode.sv | 50 +++++
 rtl/control_sequencer.sv | 149 ++++++++++++++
 tb/tb_control_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared opcodes, FSM encoding, instruction field offsets and decode class flags
//   Imported by control_sequencer and control_sequencer_instr_decode.
//   TIMEOUT_CYC is only consumed when CTRL_TIMEOUT_EN is defined.
package control_sequencer_pkg;

    localparam int TIMEOUT_CYC = 16;

    localparam int OP_LSB = 12;
    localparam int DA_LSB = 10;
    localparam int AA_LSB = 8;
    localparam int BA_LSB = 6;
    localparam int IMM_W  = 6;

    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_BRZ  = 4'hC;
    localparam logic [3:0] OP_BRN  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Instruction class: what the sequencer has to do beyond driving the control word.
    typedef struct packed {
        logic wr;
        logic flags;
        logic mem;
        logic st;
        logic brz;
        logic brn;
        logic jmp;
        logic halt;
    } cls_t;

    function automatic logic [3:0] op_of(input logic [15:0] ir);
        return ir[OP_LSB +: 4];
    endfunction

endpackage

// File: rtl/control_sequencer_instr_decode.sv
// control_sequencer_instr_decode: combinational IR -> datapath control word and instruction class
//   ir_i         in   16    latched instruction
//   da_o/aa_o/ba_o out 2    register selects
//   mb_o         out  1     B operand from constant
//   md_o         out  1     write data from memory
//   fs_o         out  4     function-unit select
//   const_o      out  SIZE  zero-extended imm[5:0]
//   cls_o        out  cls_t instruction class flags
module control_sequencer_instr_decode
    import control_sequencer_pkg::*;
#(
    parameter int         SIZE     = 8,
    parameter logic [3:0] FS_ADD   = 4'b0010,
    parameter logic [3:0] FS_PASSB = 4'b1100
) (
    input  logic [15:0]     ir_i,
    output logic [1:0]      da_o,
    output logic [1:0]      aa_o,
    output logic [1:0]      ba_o,
    output logic            mb_o,
    output logic            md_o,
    output logic [3:0]      fs_o,
    output logic [SIZE-1:0] const_o,
    output cls_t            cls_o
);

    logic [3:0] op;
    logic       alu;

    always_comb begin
        op         = op_of(ir_i);
        alu        = ~op[3];
        da_o       = ir_i[DA_LSB +: 2];
        aa_o       = ir_i[AA_LSB +: 2];
        ba_o       = ir_i[BA_LSB +: 2];
        mb_o       = (op == OP_ADDI) || (op == OP_LDI);
        md_o       = op == OP_LD;
        fs_o       = alu ? {1'b0, op[2:0]} : (op == OP_ADDI) ? FS_ADD : (op == OP_LDI) ? FS_PASSB : 4'b0000;
        const_o    = SIZE'(ir_i[IMM_W-1:0]);
        cls_o.wr    = alu || mb_o;
        cls_o.flags = alu || (op == OP_ADDI);
        cls_o.mem   = (op == OP_LD) || (op == OP_ST);
        cls_o.st    = op == OP_ST;
        cls_o.brz   = op == OP_BRZ;
        cls_o.brn   = op == OP_BRN;
        cls_o.jmp   = op == OP_JMP;
        cls_o.halt  = op == OP_HALT;
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/EXEC/MEM/HALT sequencer for the 8-bit register/ALU datapath
//   Owns PC, IR and the latched {V,C,N,Z} flag register.
//   Optional feature macro CTRL_TIMEOUT_EN: ack timeout that drops the request, sets timeout_err and halts.
//   clk, rst_n            clock, synchronous active-low reset
//   imem_addr/req/ack/data instruction fetch handshake (req held until ack)
//   dmem_req/we/ack       data load/store handshake (req held until ack)
//   DA,AA,BA,MB,MD,RW,FS,constant_out  datapath control word
//   V,C,N,Z,jump_addr     datapath flags and register-A value
//   halted, timeout_err   status
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int         SIZE     = 8,
    parameter logic [3:0] FS_ADD   = 4'b0010,
    parameter logic [3:0] FS_PASSB = 4'b1100
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [SIZE-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [1:0]      DA,
    output logic [1:0]      AA,
    output logic [1:0]      BA,
    output logic            MB,
    output logic            MD,
    output logic            RW,
    output logic [3:0]      FS,
    output logic [SIZE-1:0] constant_out,
    input  logic            V,
    input  logic            C,
    input  logic            N,
    input  logic            Z,
    input  logic [SIZE-1:0] jump_addr,
    output logic            halted,
    output logic            timeout_err
);

    state_t          state_q, state_d;
    logic [SIZE-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [3:0]      flags_q, flags_d;
    cls_t            cls;
    logic [SIZE-1:0] imm_sext;

`ifdef CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          tmo;
`endif

    control_sequencer_instr_decode #(
        .SIZE    (SIZE),
        .FS_ADD  (FS_ADD),
        .FS_PASSB(FS_PASSB)
    ) u_dec (
        .ir_i   (ir_q),
        .da_o   (DA),
        .aa_o   (AA),
        .ba_o   (BA),
        .mb_o   (MB),
        .md_o   (MD),
        .fs_o   (FS),
        .const_o(constant_out),
        .cls_o  (cls)
    );

    assign imm_sext = {{(SIZE-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
`ifdef CTRL_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
`ifdef CTRL_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // flags_q = {V,C,N,Z}; branches test the value latched by an earlier instruction.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        case (state_q)
            ST_FETCH: if (imem_ack) begin
                state_d = ST_EXEC;
                ir_d    = imem_data;
                pc_d    = pc_q + SIZE'(1);
            end
            ST_EXEC: begin
                state_d = cls.mem ? ST_MEM : cls.halt ? ST_HALT : ST_FETCH;
                if (cls.flags) flags_d = {V, C, N, Z};
                if ((cls.brz && flags_q[0]) || (cls.brn && flags_q[1])) pc_d = pc_q + imm_sext;
                else if (cls.jmp) pc_d = jump_addr;
            end
            ST_MEM: if (dmem_ack) state_d = ST_FETCH;
            default: ;
        endcase
`ifdef CTRL_TIMEOUT_EN
        // Counter runs only while a request is waiting and restarts on every new wait.
        tmo   = 1'b0;
        cnt_d = '0;
        err_d = err_q;
        if ((state_q == ST_FETCH && !imem_ack) || (state_q == ST_MEM && !dmem_ack)) begin
            tmo   = cnt_q == CW'(TIMEOUT_CYC - 1);
            cnt_d = tmo ? '0 : cnt_q + CW'(1);
            if (tmo) begin
                state_d = ST_HALT;
                err_d   = 1'b1;
            end
        end
`endif
    end

    // Requests and RW are gated by rst_n so a reset cycle never issues a request or a register write.
    always_comb begin
        imem_addr = pc_q;
        imem_req  = rst_n && (state_q == ST_FETCH);
        dmem_req  = rst_n && (state_q == ST_MEM);
        dmem_we   = dmem_req && cls.st;
        RW        = rst_n && ((state_q == ST_EXEC && cls.wr) || (state_q == ST_MEM && dmem_ack && !cls.st));
        halted    = state_q == ST_HALT;
`ifdef CTRL_TIMEOUT_EN
        timeout_err = err_q;
`else
        timeout_err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer
//   Expected fetch addresses are queued as instructions are issued and popped at each new fetch request.
//   The timeout section follows CTRL_TIMEOUT_EN the same way as the design.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [1:0]  DA, AA, BA;
    logic        MB, MD, RW;
    logic [3:0]  FS;
    logic [7:0]  constant_out;
    logic        V, C, N, Z;
    logic [7:0]  jump_addr;
    logic        halted;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_addr[$];

    control_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .DA(DA), .AA(AA), .BA(BA), .MB(MB), .MD(MD), .RW(RW), .FS(FS), .constant_out(constant_out),
        .V(V), .C(C), .N(N), .Z(Z), .jump_addr(jump_addr),
        .halted(halted), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Waits (bounded) for a fetch request, checks its address against the scoreboard,
    // withholds ack for wait_cyc cycles, then returns in the EXEC cycle.
    task automatic fetch(input logic [15:0] ins, input int wait_cyc);
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        check("imem_req", 16'(imem_req), 16'd1);
        if (exp_addr.size() > 0) begin
            check("imem_addr", 16'(imem_addr), 16'(exp_addr.pop_front()));
        end else begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_empty: observed fetch at %0h expected none", imem_addr);
        end
        repeat (wait_cyc) step();
        imem_ack  = 1'b1;
        imem_data = ins;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0; dmem_ack = 1'b0;
        V = 1'b0; C = 1'b0; N = 1'b0; Z = 1'b0; jump_addr = '0;
        step();
        step();
        check("rst_imem_addr", 16'(imem_addr), 16'h0);
        check("rst_imem_req", 16'(imem_req), 16'h0);
        check("rst_dmem_req", 16'(dmem_req), 16'h0);
        check("rst_dmem_we", 16'(dmem_we), 16'h0);
        check("rst_rw", 16'(RW), 16'h0);
        check("rst_mb", 16'(MB), 16'h0);
        check("rst_md", 16'(MD), 16'h0);
        check("rst_halted", 16'(halted), 16'h0);
        check("rst_timeout_err", 16'(timeout_err), 16'h0);
        rst_n = 1'b1;
        #1;
        // LDI R1,5
        exp_addr.push_back(8'h00);
        fetch(16'h9405, 2);
        check("ldi_const", 16'(constant_out), 16'h05);
        check("ldi_mb", 16'(MB), 16'h1);
        check("ldi_fs", 16'(FS), 16'hC);
        check("ldi_da", 16'(DA), 16'h1);
        check("ldi_rw", 16'(RW), 16'h1);
        step();
        check("ldi_rw_pulse", 16'(RW), 16'h0);
        // ALU op (FS=1) producing Z=1
        exp_addr.push_back(8'h01);
        fetch(16'h1000, 0);
        check("alu_fs", 16'(FS), 16'h1);
        check("alu_mb", 16'(MB), 16'h0);
        check("alu_rw", 16'(RW), 16'h1);
        Z = 1'b1;
        step();
        Z = 1'b0;
        // Two LDIs leave flags alone and move PC to 4
        exp_addr.push_back(8'h02);
        fetch(16'h9803, 1);
        step();
        exp_addr.push_back(8'h03);
        fetch(16'h9C07, 0);
        step();
        // BRZ -2 at 0x04 taken -> 0x03
        exp_addr.push_back(8'h04);
        fetch(16'hC03E, 0);
        check("brz_rw", 16'(RW), 16'h0);
        step();
        // BRN -2 at 0x03 not taken (N=0) -> 0x04
        exp_addr.push_back(8'h03);
        fetch(16'hD03E, 0);
        step();
        // JMP to 0xFF, then non-branch at 0xFF wraps to 0x00
        exp_addr.push_back(8'h04);
        fetch(16'hE000, 0);
        jump_addr = 8'hFF;
        step();
        exp_addr.push_back(8'hFF);
        fetch(16'h9401, 0);
        step();
        exp_addr.push_back(8'h00);
        fetch(16'hE000, 0);
        jump_addr = 8'h80;
        step();
        // LD with ack delayed 3 cycles
        exp_addr.push_back(8'h80);
        fetch(16'hA100, 0);
        check("ld_exec_rw", 16'(RW), 16'h0);
        check("ld_exec_dreq", 16'(dmem_req), 16'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            check("ld_wait_dreq", 16'(dmem_req), 16'h1);
            check("ld_wait_we", 16'(dmem_we), 16'h0);
            check("ld_wait_rw", 16'(RW), 16'h0);
            step();
        end
        dmem_ack = 1'b1;
        #1;
        check("ld_ack_rw", 16'(RW), 16'h1);
        check("ld_ack_md", 16'(MD), 16'h1);
        step();
        dmem_ack = 1'b0;
        check("ld_done_dreq", 16'(dmem_req), 16'h0);
        check("ld_done_rw", 16'(RW), 16'h0);
        // ST: dmem_we high, no register write on ack
        exp_addr.push_back(8'h81);
        fetch(16'hB140, 0);
        step();
        check("st_dreq", 16'(dmem_req), 16'h1);
        check("st_we", 16'(dmem_we), 16'h1);
        dmem_ack = 1'b1;
        #1;
        check("st_ack_rw", 16'(RW), 16'h0);
        step();
        dmem_ack = 1'b0;
        // Reset during MEM wait aborts the load
        exp_addr.push_back(8'h82);
        fetch(16'hA200, 0);
        step();
        check("rst_mem_dreq_before", 16'(dmem_req), 16'h1);
        rst_n = 1'b0;
        dmem_ack = 1'b1;
        #1;
        check("rst_mem_rw", 16'(RW), 16'h0);
        step();
        dmem_ack = 1'b0;
        check("rst_mem_dreq", 16'(dmem_req), 16'h0);
        check("rst_mem_addr", 16'(imem_addr), 16'h0);
        check("rst_mem_ireq", 16'(imem_req), 16'h0);
        rst_n = 1'b1;
        #1;
        // HALT: no requests, stray acks ignored
        exp_addr.delete();
        exp_addr.push_back(8'h00);
        fetch(16'hF000, 0);
        step();
        check("halt_halted", 16'(halted), 16'h1);
        check("halt_ireq", 16'(imem_req), 16'h0);
        check("halt_dreq", 16'(dmem_req), 16'h0);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        step();
        step();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        check("halt_stray_halted", 16'(halted), 16'h1);
        check("halt_stray_addr", 16'(imem_addr), 16'h01);
        check("halt_stray_rw", 16'(RW), 16'h0);
        // Withheld instruction ack
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
`ifdef CTRL_TIMEOUT_EN
        repeat (15) step();
        check("tmo_req_before", 16'(imem_req), 16'h1);
        check("tmo_err_before", 16'(timeout_err), 16'h0);
        step();
        check("tmo_req_after", 16'(imem_req), 16'h0);
        check("tmo_err_after", 16'(timeout_err), 16'h1);
        check("tmo_halted", 16'(halted), 16'h1);
`else
        repeat (20) step();
        check("notmo_req", 16'(imem_req), 16'h1);
        check("notmo_err", 16'(timeout_err), 16'h0);
        check("notmo_halted", 16'(halted), 16'h0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
